frame_draw_sched: RTL and testbench

- Per-frame scheduler for the frame-buffer write port.
- On each frame_start it runs the enabled draw clients in fixed priority order, for example background, then sprites, then draw_score. For each client it pulses start and waits for done.
- It routes only the active client's frame write interface (addr/data/we/rdy) to the single frame-buffer port.
- A per-client watchdog aborts hung clients. Sticky error flags report timeouts and frame overruns.

---
 rtl/draw_pkg.sv | 14 +
 rtl/fb_port_mux.sv | 32 +++
 rtl/frame_draw_sched.sv | 100 ++++++++++
 tb/tb_frame_draw_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// draw_pkg: shared widths, scheduler state encoding and client index constants
package draw_pkg;
  localparam int FB_ADDR_W = 19;
  localparam int FB_DATA_W = 32;
  localparam int CL_BG     = 0;
  localparam int CL_SPRITE = 1;
  localparam int CL_SCORE  = 2;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_NEXT  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;
endpackage

// File: rtl/fb_port_mux.sv
// fb_port_mux: routes the active client's write interface to the frame-buffer port
module fb_port_mux
  import draw_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter int IDX_W = 2
) (
  input  logic                             live,
  input  logic [IDX_W-1:0]                 idx,
  input  logic [NUM_CLIENTS*FB_ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*FB_DATA_W-1:0] cl_data,
  input  logic [NUM_CLIENTS-1:0]           cl_we,
  input  logic                             fb_rdy,
  output logic [NUM_CLIENTS-1:0]           cl_rdy,
  output logic [FB_ADDR_W-1:0]             fb_addr,
  output logic [FB_DATA_W-1:0]             fb_data,
  output logic                             fb_we
);
  always_comb begin
    fb_addr = '0;
    fb_data = '0;
    fb_we   = 1'b0;
    cl_rdy  = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      if (live && idx == IDX_W'(i)) begin
        fb_addr   = cl_addr[i*FB_ADDR_W +: FB_ADDR_W];
        fb_data   = cl_data[i*FB_DATA_W +: FB_DATA_W];
        fb_we     = cl_we[i];
        cl_rdy[i] = fb_rdy;
      end
  end
endmodule

// File: rtl/frame_draw_sched.sv
// frame_draw_sched: per-frame priority sequencer of draw clients with watchdog and sticky errors
module frame_draw_sched
  import draw_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter int IDX_W = 2,
  parameter int WDOG_W = 21
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic [NUM_CLIENTS-1:0]           client_en,
  input  logic                             clr_err,
  output logic [NUM_CLIENTS-1:0]           cl_start,
  input  logic [NUM_CLIENTS-1:0]           cl_done,
  input  logic [NUM_CLIENTS*FB_ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*FB_DATA_W-1:0] cl_data,
  input  logic [NUM_CLIENTS-1:0]           cl_we,
  output logic [NUM_CLIENTS-1:0]           cl_rdy,
  output logic [FB_ADDR_W-1:0]             fb_addr,
  output logic [FB_DATA_W-1:0]             fb_data,
  output logic                             fb_we,
  input  logic                             fb_rdy,
  output logic                             busy,
  output logic [IDX_W-1:0]                 active_id,
  output logic                             frame_done,
  output logic                             timeout_err,
  output logic                             overrun_err
);
  state_t state, state_nx;
  logic [NUM_CLIENTS-1:0] en_q;
  logic [IDX_W-1:0] idx, first_idx, next_idx;
  logic has_next, done_act, tmo;
  logic [WDOG_W-1:0] wdog;
  assign done_act = cl_done[idx];
  assign tmo = state == ST_WAIT && !done_act && &wdog;
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (client_en[i]) first_idx = IDX_W'(i);
      if (en_q[i] && i > int'(idx)) begin
        next_idx = IDX_W'(i);
        has_next = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (frame_start) state_nx = client_en == '0 ? ST_DONE : ST_START;
      ST_START: state_nx = ST_WAIT;
      ST_WAIT:  if (done_act || tmo) state_nx = ST_NEXT;
      ST_NEXT:  state_nx = has_next ? ST_START : ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= '0;
      idx         <= '0;
      wdog        <= '0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (state == ST_IDLE && frame_start) begin
        en_q <= client_en;
        idx  <= first_idx;
      end
      if (state == ST_NEXT && has_next) idx <= next_idx;
      wdog        <= state == ST_START ? '0 : state == ST_WAIT ? wdog + 1'b1 : wdog;
      timeout_err <= tmo | (timeout_err & ~clr_err);
      overrun_err <= (busy & frame_start) | (overrun_err & ~clr_err);
    end
  end
  always_comb begin
    cl_start   = state == ST_START ? NUM_CLIENTS'(1) << idx : '0;
    busy       = state != ST_IDLE;
    frame_done = state == ST_DONE;
    active_id  = idx;
  end
  fb_port_mux #(.NUM_CLIENTS(NUM_CLIENTS), .IDX_W(IDX_W)) u_mux (
    .live   (state == ST_WAIT),
    .idx    (idx),
    .cl_addr(cl_addr),
    .cl_data(cl_data),
    .cl_we  (cl_we),
    .fb_rdy (fb_rdy),
    .cl_rdy (cl_rdy),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .fb_we  (fb_we)
  );
endmodule

// File: tb/tb_frame_draw_sched.sv
// tb_frame_draw_sched: randomized client emulation checked against a timeline model of the schedule
module tb_frame_draw_sched;
  import draw_pkg::*;
  localparam int NC = 3;
  localparam int TMO = 15;
  localparam int NEVER = 1000000;
  logic clk = 1'b0;
  logic rst, frame_start, clr_err, fb_rdy, fb_we, busy, frame_done, timeout_err, overrun_err;
  logic [NC-1:0] client_en, cl_start, cl_done, cl_we, cl_rdy;
  logic [NC*FB_ADDR_W-1:0] cl_addr;
  logic [NC*FB_DATA_W-1:0] cl_data;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [FB_DATA_W-1:0] fb_data;
  logic [1:0] active_id;
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;
  frame_draw_sched #(.NUM_CLIENTS(NC), .IDX_W(2), .WDOG_W(4)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .client_en(client_en), .clr_err(clr_err),
    .cl_start(cl_start), .cl_done(cl_done), .cl_addr(cl_addr), .cl_data(cl_data), .cl_we(cl_we),
    .cl_rdy(cl_rdy), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_rdy(fb_rdy),
    .busy(busy), .active_id(active_id), .frame_done(frame_done), .timeout_err(timeout_err),
    .overrun_err(overrun_err)
  );

  // Client i with delay d pulses done in its WAIT cycle d; beyond TMO it hangs and the watchdog ends it.
  task automatic run_frame(input logic [2:0] en, input int d0, input int d1, input int d2,
                           input bit fixed, input bit bp, input int ov,
                           output int writes, output int dones);
    int dly[NC], st[NC], en_c[NC];
    int s, done_c, to_c, ov_e, a, w, exp_w;
    logic [NC-1:0] we_v, dn_v, st_e, rdy_e;
    logic [FB_ADDR_W-1:0] ad[NC];
    logic [FB_DATA_W-1:0] da[NC];
    logic r, we_e;
    logic [FB_ADDR_W-1:0] ad_e;
    logic [FB_DATA_W-1:0] da_e;
    dly = '{d0, d1, d2};
    s = 1;
    to_c = NEVER;
    for (int i = 0; i < NC; i++) begin
      if (en[i]) begin
        st[i] = s;
        en_c[i] = s + 1 + (dly[i] < TMO ? dly[i] : TMO);
        if (dly[i] > TMO && to_c == NEVER) to_c = en_c[i];
        s = en_c[i] + 2;
      end else begin
        st[i] = -10;
        en_c[i] = -10;
      end
    end
    done_c = s;
    ov_e = (ov >= 1 && ov <= done_c) ? ov : NEVER;
    writes = 0;
    dones = 0;
    exp_w = 0;
    for (int c = 0; c <= done_c + 1; c++) begin
      @(negedge clk);
      a = -1;
      for (int i = 0; i < NC; i++) if (c > st[i] && c <= en_c[i]) a = i;
      r = fixed ? 1'b1 : (bp && a == 1 && c - st[1] - 1 < 10) ? 1'b0 : ($urandom % 4 != 0);
      for (int i = 0; i < NC; i++) begin
        w = c - st[i] - 1;
        ad[i] = (bp && i == 1) ? 19'h12345 : FB_ADDR_W'($urandom);
        da[i] = (bp && i == 1) ? 32'hFF00FF00 : $urandom;
        if (a == i) we_v[i] = fixed ? (w < 4) : (bp && i == 1) ? (w < dly[i]) : 1'($urandom);
        else we_v[i] = 1'($urandom);
        dn_v[i] = (a == i) ? (w == dly[i]) : ($urandom % 4 == 0);
      end
      frame_start = (c == 0) || (c == ov_e);
      client_en = c == 0 ? en : 3'($urandom);
      clr_err = c == 0;
      cl_we = we_v;
      cl_done = dn_v;
      cl_addr = {ad[2], ad[1], ad[0]};
      cl_data = {da[2], da[1], da[0]};
      fb_rdy = r;
      #1;
      st_e = '0;
      for (int i = 0; i < NC; i++) if (c == st[i]) st_e[i] = 1'b1;
      we_e = 1'b0; ad_e = '0; da_e = '0; rdy_e = '0;
      if (a >= 0) begin
        we_e = we_v[a]; ad_e = ad[a]; da_e = da[a];
        rdy_e[a] = r;
      end
      if (we_e && r) exp_w++;
      if (fb_we && fb_rdy) writes++;
      if (frame_done) dones++;
      checks++;
      if (cl_start !== st_e) $display("FAIL cl_start c=%0d got=%b exp=%b", c, cl_start, st_e);
      else passes++;
      checks++;
      if (fb_we !== we_e || fb_addr !== ad_e || fb_data !== da_e)
        $display("FAIL fb_port c=%0d got=%b/%h/%h exp=%b/%h/%h", c, fb_we, fb_addr, fb_data, we_e, ad_e, da_e);
      else passes++;
      checks++;
      if (cl_rdy !== rdy_e) $display("FAIL cl_rdy c=%0d got=%b exp=%b", c, cl_rdy, rdy_e);
      else passes++;
      checks++;
      if (frame_done !== (c == done_c)) $display("FAIL frame_done c=%0d got=%b exp=%b", c, frame_done, c == done_c);
      else passes++;
      checks++;
      if (busy !== (c >= 1 && c <= done_c)) $display("FAIL busy c=%0d got=%b exp=%b", c, busy, c >= 1 && c <= done_c);
      else passes++;
      if (a >= 0 || st_e != 0) begin
        w = a;
        for (int i = 0; i < NC; i++) if (st_e[i]) w = i;
        checks++;
        if (active_id !== 2'(w)) $display("FAIL active_id c=%0d got=%0d exp=%0d", c, active_id, w);
        else passes++;
      end
      if (c >= 1) begin
        checks++;
        if (timeout_err !== (c > to_c)) $display("FAIL timeout_err c=%0d got=%b exp=%b", c, timeout_err, c > to_c);
        else passes++;
        checks++;
        if (overrun_err !== (c > ov_e)) $display("FAIL overrun_err c=%0d got=%b exp=%b", c, overrun_err, c > ov_e);
        else passes++;
      end
    end
    frame_start = 1'b0;
    clr_err = 1'b0;
    cl_done = '0;
    checks++;
    if (writes !== exp_w) $display("FAIL write_count got=%0d exp=%0d", writes, exp_w);
    else passes++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; frame_start = 1'b1; client_en = '1; cl_we = '1; fb_rdy = 1'b1; cl_done = '1;
    cl_addr = '1; cl_data = '1; clr_err = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({cl_start, cl_rdy, fb_we, frame_done, busy, timeout_err, overrun_err, active_id} !== '0 ||
        fb_addr !== '0 || fb_data !== '0)
      $display("FAIL reset_state got=%b/%b/%b/%b/%b/%b/%b/%0d addr=%h data=%h exp=all zero",
               cl_start, cl_rdy, fb_we, frame_done, busy, timeout_err, overrun_err, active_id, fb_addr, fb_data);
    else passes++;
    rst = 1'b0; frame_start = 1'b0; cl_done = '0;
  endtask

  task automatic test_full_frame();
    int wr, dn;
    run_frame(3'b111, 4, 4, 4, 1'b1, 1'b0, 0, wr, dn);
    checks++;
    if (wr !== 12) $display("FAIL full_frame_writes got=%0d exp=12", wr);
    else passes++;
    checks++;
    if (dn !== 1) $display("FAIL full_frame_dones got=%0d exp=1", dn);
    else passes++;
  endtask

  task automatic test_sparse();
    int wr, dn;
    run_frame(3'b100, 0, 0, $urandom_range(0, 8), 1'b0, 1'b0, 0, wr, dn);
    run_frame(3'b000, 0, 0, 0, 1'b0, 1'b0, 0, wr, dn);
    checks++;
    if (dn !== 1) $display("FAIL empty_frame_dones got=%0d exp=1", dn);
    else passes++;
  endtask

  task automatic test_backpressure();
    int wr, dn;
    run_frame(3'b010, 0, 12, 0, 1'b0, 1'b1, 0, wr, dn);
    run_frame(3'b111, 2, 12, 3, 1'b0, 1'b1, 0, wr, dn);
  endtask

  task automatic test_watchdog();
    int wr, dn;
    run_frame(3'b001, 15, 0, 0, 1'b0, 1'b0, 0, wr, dn);
    run_frame(3'b011, 100, 3, 0, 1'b0, 1'b0, 0, wr, dn);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (timeout_err !== 1'b1) $display("FAIL timeout_sticky k=%0d got=%b exp=1", k, timeout_err);
      else passes++;
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    checks++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_clear got=%b exp=0", timeout_err);
    else passes++;
  endtask

  task automatic test_overrun_stray();
    int wr, dn;
    run_frame(3'b111, 5, 2, 6, 1'b0, 1'b0, 5, wr, dn);
    checks++;
    if (dn !== 1) $display("FAIL overrun_dones got=%0d exp=1", dn);
    else passes++;
    run_frame(3'b101, 9, 0, 1, 1'b0, 1'b0, 2, wr, dn);
  endtask

  task automatic test_reset_mid_wait();
    int wr, dn;
    @(negedge clk);
    frame_start = 1'b1; client_en = 3'b111; cl_done = '0; cl_we = 3'b111; fb_rdy = 1'b1;
    cl_addr = {19'h7, 19'h5, 19'h0ABCD};
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    checks++;
    if (cl_start !== 3'b001) $display("FAIL rmw_start got=%b exp=001", cl_start);
    else passes++;
    @(negedge clk);
    frame_start = 1'b1;
    #1;
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 19'h0ABCD) $display("FAIL rmw_live got=%b/%h exp=1/0abcd", fb_we, fb_addr);
    else passes++;
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    checks++;
    if (overrun_err !== 1'b1) $display("FAIL rmw_overrun got=%b exp=1", overrun_err);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, fb_we, frame_done, overrun_err, cl_start, active_id} !== '0)
      $display("FAIL rmw_after_reset got=%b/%b/%b/%b/%b/%0d exp=all zero",
               busy, fb_we, frame_done, overrun_err, cl_start, active_id);
    else passes++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) $display("FAIL rmw_quiet k=%0d got=%b/%b exp=0/0", k, frame_done, busy);
      else passes++;
    end
    run_frame(3'b111, 1, 2, 3, 1'b0, 1'b0, 0, wr, dn);
  endtask

  task automatic test_random();
    int wr, dn;
    for (int n = 0; n < 25; n++)
      run_frame(3'($urandom), $urandom_range(0, 17), $urandom_range(0, 17), $urandom_range(0, 17),
                1'b0, 1'b0, ($urandom % 3 == 0) ? $urandom_range(1, 40) : 0, wr, dn);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; client_en = '0; clr_err = 1'b0; cl_done = '0;
    cl_we = '0; cl_addr = '0; cl_data = '0; fb_rdy = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_full_frame();
    test_sparse();
    test_backpressure();
    test_watchdog();
    test_overrun_stray();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
